// File: rtl/seq_multiplier_ctl.sv
// Iterative shift-add multiplier (signed/unsigned per op) with IDLE/BUSY/DONE handshake.
// Optional early termination when MULT_EARLY_TERM_EN is defined.
module seq_multiplier_ctl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 in_ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic               sgn;
  logic [CNT_W-1:0]   cnt;

  logic               last, ext, ext_a, accept;
  logic [WIDTH:0]     hi, m, sum;
  logic [2*WIDTH-1:0] step_nxt, early_nxt;
  logic               early;

  assign in_ready = (state != S_BUSY);
  assign busy     = (state == S_BUSY);
  assign done     = (state == S_DONE);
  assign accept   = start && in_ready;

  // product[2W-1:W] is the running partial sum, product[W-1:0] the unconsumed multiplier bits
  always_comb begin
    last     = (cnt == CNT_W'(WIDTH-1));
    ext      = sgn & product[2*WIDTH-1];
    ext_a    = sgn & mcand[WIDTH-1];
    hi       = {ext, product[2*WIDTH-1:WIDTH]};
    m        = {ext_a, mcand};
    // the multiplier MSB carries negative weight in two's complement
    sum      = (last && sgn) ? (hi - m) : (hi + m);
    step_nxt = product[0] ? {sum, product[WIDTH-1:1]} : {ext, product[2*WIDTH-1:1]};
  end

`ifdef MULT_EARLY_TERM_EN
  logic               b_msb;
  logic [WIDTH-1:0]   rem_mask;
  logic [CNT_W-1:0]   shamt;
  logic [2*WIDTH:0]   shifted;

  always_comb begin
    rem_mask  = {WIDTH{1'b1}} >> cnt;
    early     = ((product[WIDTH-1:0] & rem_mask) == '0) && (!sgn || !b_msb);
    shamt     = CNT_W'(WIDTH) - cnt;
    shifted   = $signed({ext, product}) >>> shamt;
    early_nxt = shifted[2*WIDTH-1:0];
  end
`else
  always_comb begin
    early     = 1'b0;
    early_nxt = step_nxt;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      product <= '0;
      cnt     <= '0;
      mcand   <= '0;
      sgn     <= 1'b0;
`ifdef MULT_EARLY_TERM_EN
      b_msb   <= 1'b0;
`endif
    end else begin
      case (state)
        S_BUSY: begin
          cnt <= cnt + 1'b1;
          if (early) begin
            product <= early_nxt;
            state   <= S_DONE;
          end else begin
            product <= step_nxt;
            if (last) state <= S_DONE;
          end
        end
        default: begin
          if (accept) begin
            mcand   <= a;
            sgn     <= is_signed;
            product <= {{WIDTH{1'b0}}, b};
            cnt     <= '0;
`ifdef MULT_EARLY_TERM_EN
            b_msb   <= b[WIDTH-1];
`endif
            state   <= S_BUSY;
          end else begin
            state   <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier_ctl.sv
// Scoreboard bench for seq_multiplier_ctl: driver queues expected product/latency, monitor checks on done.
module tb_seq_multiplier_ctl;
  localparam int W = 32;

  logic            clk = 0, rst_n = 0;
  logic            start = 0, is_signed = 0;
  logic [W-1:0]    a = '0, b = '0;
  logic            in_ready, busy, done;
  logic [2*W-1:0]  product;

  seq_multiplier_ctl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .in_ready(in_ready), .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] p;
    int             acc;
    int             lat;
    string          name;
  } exp_t;

  exp_t           q[$];
  int             tests = 0, fails = 0;
  int             cyc = 0;
  logic [2*W-1:0] last_exp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic sgn, input logic [W-1:0] bv);
`ifdef MULT_EARLY_TERM_EN
    if (sgn && bv[W-1]) return W;
    for (int c = 0; c < W; c++)
      if ((bv >> c) == '0) return c + 1;
    return W;
`else
    return W;
`endif
  endfunction

  // monitor
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done: got product %h with empty scoreboard", product);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, "_product"}, product, e.p);
        chk({e.name, "_latency"}, 64'(cyc - e.acc), 64'(e.lat));
        last_exp = e.p;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL wait_ready: in_ready stuck at %b expected 1", in_ready);
    end
  endtask

  task automatic issue(input string name, input logic sgn, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [2*W-1:0] ep,
                       input bit push, input bit hold);
    exp_t e;
    wait_ready();
    start = 1; is_signed = sgn; a = av; b = bv;
    @(posedge clk); #1;
    if (push) begin
      e.p = ep; e.acc = cyc; e.lat = exp_lat(sgn, bv); e.name = name;
      q.push_back(e);
    end
    chk({name, "_busy"}, 64'(busy), 64'(1));
    if (hold) begin
      // keep requesting with different operands while the op runs
      for (int i = 0; i < 10; i++) begin
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; is_signed = ~sgn;
        @(posedge clk); #1;
      end
    end
    start = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d results outstanding, expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;
    longint       sa, sb;
    logic [2*W-1:0] re;

    #12;
    chk("rst_product", product, 0);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    rst_n = 1;

    issue("s_m3x5",     1, -32'sd3,       32'd5,        64'hFFFF_FFFF_FFFF_FFF1, 1, 0);
    issue("u_ffxff",    0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1, 0);
    issue("s_ffxff",    1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1, 1, 0);
    issue("s_minxmin",  1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1, 0);
    issue("s_minx1",    1, 32'h8000_0000, 32'd1,        64'hFFFF_FFFF_8000_0000, 1, 0);
    issue("u_7x3",      0, 32'd7,         32'd3,        64'd21, 1, 0);
    issue("u_bzero",    0, 32'h1234_5678, 32'd0,        64'd0, 1, 0);
    issue("s_5xm1",     1, 32'd5,         32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, 1, 0);
    issue("u_2p16sq",   0, 32'h0001_0000, 32'h0001_0000, 64'h1_0000_0000, 1, 0);
    issue("s_7xm2",     1, 32'd7,         32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF2, 1, 0);
    issue("hold_6x7",   0, 32'd6,         32'd7,        64'd42, 1, 1);
    drain();

    // product holds in IDLE
    repeat (3) @(negedge clk);
    chk("idle_hold", product, last_exp);

    // reset mid-operation discards the op
    issue("rst_op", 0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 64'd0, 0, 0);
    repeat (9) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("midrst_product", product, 0);
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk) rst_n = 1;
    issue("post_rst", 1, -32'sd100, 32'd100, 64'hFFFF_FFFF_FFFF_D8F0, 1, 0);
    drain();

    for (int i = 0; i < 100; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom();
      rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 300)) : $urandom();
      if (rs) begin
        sa = longint'($signed(ra)); sb = longint'($signed(rb));
      end else begin
        sa = longint'({32'd0, ra}); sb = longint'({32'd0, rb});
      end
      re = 64'(sa * sb);
      issue("rand", rs, ra, rb, re, 1, 0);
    end
    drain();
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
